// File: rtl/alu_pkg.sv
// Shared ALU definitions: MIPS-style alucontrol opcodes and the arbiter state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU.
// Ports:
//   A, B        in  n  operands
//   alucontrol  in  4  opcode (see alu_pkg)
//   Z           out n  result; undefined opcodes yield zero
module alu
    import alu_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [3:0]   alucontrol,
    output logic [n-1:0] Z
);

    always_comb begin
        Z = '0;
        case (alucontrol)
            ALU_AND: Z = A & B;
            ALU_OR:  Z = A | B;
            ALU_ADD: Z = A + B;
            ALU_SUB: Z = A - B;
            // Signed compare, result zero-extended to the datapath width.
            ALU_SLT: Z = {{(n-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Z = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Each accepted request is sequenced IDLE -> EXEC -> RESP; the tagged result is
// held in RESP until the consumer accepts it.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  2-bit request handshake (req_ready one-hot or zero)
//   a0, b0, op0          requester 0 operation
//   a1, b1, op1          requester 1 operation
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_z        owner of the result and the result itself
//   busy                 state is not IDLE
//   ops_done             wrapping count of completed responses
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [n-1:0] a0,
    input  logic [n-1:0] b0,
    input  logic [3:0]   op0,
    input  logic [n-1:0] a1,
    input  logic [n-1:0] b1,
    input  logic [3:0]   op1,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [n-1:0] rsp_z,
    input  logic         rsp_ready,
    output logic         busy,
    output logic [15:0]  ops_done
);

    arb_state_t   state_q;
    logic         last_grant_q;
    logic [n-1:0] a_q;
    logic [n-1:0] b_q;
    logic [3:0]   op_q;
    logic [n-1:0] rsp_z_q;
    logic         rsp_id_q;
    logic [15:0]  ops_cnt_q;

    logic         grant_id;
    logic         grant_en;
    logic [n-1:0] alu_z;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
        grant_en  = (state_q == IDLE) && (req_valid != 2'b00) && !rst;
        req_ready = 2'b00;
        if (grant_en) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    alu #(
        .n(n)
    ) u_alu (
        .A          (a_q),
        .B          (b_q),
        .alucontrol (op_q),
        .Z          (alu_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_z_q      <= '0;
            rsp_id_q     <= 1'b0;
            ops_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        a_q          <= grant_id ? a1 : a0;
                        b_q          <= grant_id ? b1 : b0;
                        op_q         <= grant_id ? op1 : op0;
                        rsp_id_q     <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_z_q <= alu_z;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ops_cnt_q <= ops_cnt_q + 16'd1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_z     = rsp_z_q;
    assign rsp_id    = rsp_id_q;
    assign ops_done  = ops_cnt_q;

endmodule
